// File: rtl/fib_arbiter.sv
// Two-requester round-robin front end for a shared Fibonacci stepping datapath.
// Each granted command seeds a=b=1, steps k times and returns a = F(k+2) mod 2^WIDTH.
module fib_arbiter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [CNT_W-1:0] req0_steps,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [CNT_W-1:0] req1_steps,
   output logic             req1_ready,
   output logic             rsp0_valid,
   output logic [WIDTH-1:0] rsp0_data,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   output logic [WIDTH-1:0] rsp1_data,
   input  logic             rsp1_ready,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

   localparam logic [WIDTH-1:0] SEED    = WIDTH'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             owner_q, owner_d;
   logic             last_grant_q, last_grant_d;
   logic             rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
   logic [WIDTH-1:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;

   logic grant_valid, grant_id, accept;
   logic rsp_valid_sel, rsp_ready_sel, rsp_done;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      grant_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid) grant_id = ~last_grant_q;
      else                          grant_id = req1_valid;
   end

   assign accept        = (state_q == IDLE) && grant_valid;
   assign rsp_valid_sel = owner_q ? rsp1_valid_q : rsp0_valid_q;
   assign rsp_ready_sel = owner_q ? rsp1_ready : rsp0_ready;
   assign rsp_done      = rsp_valid_sel & rsp_ready_sel;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         a_q          <= SEED;
         b_q          <= SEED;
         cnt_q        <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp0_data_q  <= '0;
         rsp1_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp0_data_q  <= rsp0_data_d;
         rsp1_data_q  <= rsp1_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = LOAD;
         LOAD: state_d = (cnt_q == '0) ? RESP : RUN;
         RUN:  if (cnt_q == CNT_ONE) state_d = RESP;
         RESP: if (rsp_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (accept) begin
         req0_ready = ~grant_id;
         req1_ready = grant_id;
      end
      busy = (state_q != IDLE);
   end

   // The response is registered on the first RESP cycle, one edge after entering RESP.
   always_comb begin
      a_d          = a_q;
      b_d          = b_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp1_valid_d = rsp1_valid_q;
      rsp0_data_d  = rsp0_data_q;
      rsp1_data_d  = rsp1_data_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d      = grant_id;
               last_grant_d = grant_id;
               cnt_d        = grant_id ? req1_steps : req0_steps;
            end
         end
         LOAD: begin
            a_d = SEED;
            b_d = SEED;
         end
         RUN: begin
            a_d   = a_q + b_q;
            b_d   = a_q;
            cnt_d = cnt_q - CNT_ONE;
         end
         RESP: begin
            if (rsp_done) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
            end else if (!rsp_valid_sel) begin
               if (owner_q) begin
                  rsp1_valid_d = 1'b1;
                  rsp1_data_d  = a_q;
               end else begin
                  rsp0_valid_d = 1'b1;
                  rsp0_data_d  = a_q;
               end
            end
         end
         default: ;
      endcase
   end

   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp0_data  = rsp0_data_q;
   assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_fib_arbiter.sv
// Directed self-checking bench for fib_arbiter: grants, latency, results, stalls and reset abort.
module tb_fib_arbiter;

   logic       clock = 1'b0;
   logic       reset;
   logic       req0_valid, req1_valid, req0_ready, req1_ready;
   logic [7:0] req0_steps, req1_steps;
   logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
   logic [7:0] rsp0_data, rsp1_data;
   logic       busy;

   int checks = 0;
   int passes = 0;

   fib_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_steps(req0_steps), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_steps(req1_steps), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
      .busy(busy)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Called at a negedge; returns at a negedge with reset released.
   task automatic do_reset();
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_steps = '0;   req1_steps = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      @(negedge clock); @(negedge clock);
      reset = 1'b0;
   endtask

   // Issues one command from an idle DUT with the response ready already high.
   task automatic do_cmd(input bit who, input logic [7:0] k, output bit ready_seen,
                         output int cycles, output logic [7:0] data,
                         output bit busy_ok, output bit other_quiet);
      if (who) begin req1_valid = 1'b1; req1_steps = k; end
      else     begin req0_valid = 1'b1; req0_steps = k; end
      #1;
      ready_seen = who ? req1_ready : req0_ready;
      @(posedge clock); @(negedge clock);
      req0_valid = 1'b0; req1_valid = 1'b0;
      cycles = 0; busy_ok = 1'b1; other_quiet = 1'b1;
      while (!(who ? rsp1_valid : rsp0_valid) && cycles < 600) begin
         if (!busy || req0_ready || req1_ready) busy_ok = 1'b0;
         if (who ? rsp0_valid : rsp1_valid) other_quiet = 1'b0;
         @(negedge clock);
         cycles++;
      end
      if (who ? rsp0_valid : rsp1_valid) other_quiet = 1'b0;
      data = who ? rsp1_data : rsp0_data;
      @(negedge clock);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", busy); else passes++;
      checks++; if ({req0_ready, req1_ready} !== 2'b00) $display("[TB] FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready}); else passes++;
      checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) $display("[TB] FAIL reset_rsp_valid: got %b expected 00", {rsp0_valid, rsp1_valid}); else passes++;
      checks++; if ({rsp0_data, rsp1_data} !== 16'h0) $display("[TB] FAIL reset_rsp_data: got %h expected 0000", {rsp0_data, rsp1_data}); else passes++;
   endtask

   task automatic test_basic();
      bit rdy, bok, oq; int cyc; logic [7:0] d;
      rsp0_ready = 1'b1;
      do_cmd(1'b0, 8'd4, rdy, cyc, d, bok, oq);
      checks++; if (rdy !== 1'b1) $display("[TB] FAIL basic_ready: got %0b expected 1", rdy); else passes++;
      checks++; if (cyc != 6) $display("[TB] FAIL basic_latency: got %0d expected 6", cyc); else passes++;
      checks++; if (d !== 8'd8) $display("[TB] FAIL basic_data: got %0d expected 8", d); else passes++;
      checks++; if (bok !== 1'b1) $display("[TB] FAIL basic_busy: got %0b expected 1", bok); else passes++;
      checks++; if (oq !== 1'b1) $display("[TB] FAIL basic_rsp1_quiet: got %0b expected 1", oq); else passes++;
      checks++; if ({rsp0_valid, busy} !== 2'b00) $display("[TB] FAIL basic_after_hs: got %b expected 00", {rsp0_valid, busy}); else passes++;
   endtask

   task automatic test_wrap();
      bit rdy, bok, oq; int cyc; logic [7:0] d;
      logic [7:0] ks [3]  = '{8'd10, 8'd12, 8'd11};
      logic [7:0] exp [3] = '{8'd144, 8'd121, 8'd233};
      rsp1_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         do_cmd(1'b1, ks[i], rdy, cyc, d, bok, oq);
         checks++; if (d !== exp[i]) $display("[TB] FAIL wrap_data_k%0d: got %0d expected %0d", ks[i], d, exp[i]); else passes++;
         checks++; if (cyc != int'(ks[i]) + 2) $display("[TB] FAIL wrap_latency_k%0d: got %0d expected %0d", ks[i], cyc, int'(ks[i]) + 2); else passes++;
      end
   endtask

   task automatic test_alternate();
      int cyc; bit g; logic [7:0] d;
      do_reset();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1; req0_steps = '0; req1_steps = '0;
      for (int i = 0; i < 4; i++) begin
         #1;
         g = req1_ready;
         checks++; if ({req1_ready, req0_ready} !== ((i % 2) ? 2'b10 : 2'b01)) $display("[TB] FAIL alt_grant_%0d: got %b expected %b", i, {req1_ready, req0_ready}, (i % 2) ? 2'b10 : 2'b01); else passes++;
         @(posedge clock); @(negedge clock);
         cyc = 0;
         while (!(g ? rsp1_valid : rsp0_valid) && cyc < 50) begin
            @(negedge clock); cyc++;
         end
         d = g ? rsp1_data : rsp0_data;
         checks++; if (cyc != 2 || d !== 8'd1) $display("[TB] FAIL alt_rsp_%0d: got lat %0d data %0d expected lat 2 data 1", i, cyc, d); else passes++;
         @(negedge clock);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_stall();
      int cyc; bit stable;
      do_reset();
      rsp0_ready = 1'b0; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_steps = 8'd3;
      @(posedge clock); @(negedge clock);
      req0_valid = 1'b0; req1_valid = 1'b1; req1_steps = 8'd2;
      cyc = 0;
      while (!rsp0_valid && cyc < 50) begin
         @(negedge clock); cyc++;
      end
      checks++; if (cyc != 5) $display("[TB] FAIL stall_latency: got %0d expected 5", cyc); else passes++;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (rsp0_valid !== 1'b1 || rsp0_data !== 8'd5 || req1_ready !== 1'b0 || rsp1_valid !== 1'b0) stable = 1'b0;
         @(negedge clock);
      end
      checks++; if (stable !== 1'b1) $display("[TB] FAIL stall_hold: got %0b expected 1", stable); else passes++;
      rsp0_ready = 1'b1;
      @(negedge clock);
      #1;
      checks++; if ({rsp0_valid, req1_ready} !== 2'b01) $display("[TB] FAIL stall_release: got %b expected 01", {rsp0_valid, req1_ready}); else passes++;
      @(posedge clock); @(negedge clock);
      req1_valid = 1'b0;
      cyc = 0;
      while (!rsp1_valid && cyc < 50) begin
         @(negedge clock); cyc++;
      end
      checks++; if (cyc != 4 || rsp1_data !== 8'd3) $display("[TB] FAIL stall_req1: got lat %0d data %0d expected lat 4 data 3", cyc, rsp1_data); else passes++;
      @(negedge clock);
   endtask

   task automatic test_reset_mid_run();
      bit rdy, bok, oq, quiet; int cyc; logic [7:0] d;
      do_reset();
      rsp0_ready = 1'b1;
      do_cmd(1'b0, 8'd0, rdy, cyc, d, bok, oq);
      checks++; if (d !== 8'd1) $display("[TB] FAIL abort_pre_data: got %0d expected 1", d); else passes++;
      req0_valid = 1'b1; req0_steps = 8'd20;
      @(posedge clock); @(negedge clock);
      req0_valid = 1'b0;
      repeat (4) @(negedge clock);
      checks++; if (busy !== 1'b1) $display("[TB] FAIL abort_running: got %0b expected 1", busy); else passes++;
      reset = 1'b1;
      @(negedge clock);
      checks++; if ({busy, rsp0_valid, rsp1_valid, rsp0_data} !== 11'h0) $display("[TB] FAIL abort_reset_vals: got %h expected 000", {busy, rsp0_valid, rsp1_valid, rsp0_data}); else passes++;
      reset = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (rsp0_valid || rsp1_valid || busy) quiet = 1'b0;
         @(negedge clock);
      end
      checks++; if (quiet !== 1'b1) $display("[TB] FAIL abort_no_rsp: got %0b expected 1", quiet); else passes++;
      do_cmd(1'b0, 8'd1, rdy, cyc, d, bok, oq);
      checks++; if (cyc != 3 || d !== 8'd2) $display("[TB] FAIL abort_next: got lat %0d data %0d expected lat 3 data 2", cyc, d); else passes++;
   endtask

   task automatic test_back_to_back();
      bit rdy, bok, oq; int cyc; logic [7:0] d;
      do_reset();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      do_cmd(1'b1, 8'd1, rdy, cyc, d, bok, oq);
      checks++; if (rdy !== 1'b1 || d !== 8'd2) $display("[TB] FAIL b2b_req1_first: got ready %0b data %0d expected ready 1 data 2", rdy, d); else passes++;
      req0_valid = 1'b1; req1_valid = 1'b1; req0_steps = '0; req1_steps = '0;
      #1;
      checks++; if ({req1_ready, req0_ready} !== 2'b01) $display("[TB] FAIL b2b_tie: got %b expected 01", {req1_ready, req0_ready}); else passes++;
      @(posedge clock); @(negedge clock);
      req0_valid = 1'b0;
      cyc = 0;
      while (!rsp0_valid && cyc < 50) begin
         @(negedge clock); cyc++;
      end
      checks++; if (cyc != 2 || rsp0_data !== 8'd1) $display("[TB] FAIL b2b_req0_rsp: got lat %0d data %0d expected lat 2 data 1", cyc, rsp0_data); else passes++;
      @(negedge clock);
      #1;
      checks++; if ({req1_ready, req0_ready} !== 2'b10) $display("[TB] FAIL b2b_req1_next: got %b expected 10", {req1_ready, req0_ready}); else passes++;
      @(posedge clock); @(negedge clock);
      req1_valid = 1'b0;
      cyc = 0;
      while (!rsp1_valid && cyc < 50) begin
         @(negedge clock); cyc++;
      end
      checks++; if (cyc != 2 || rsp1_data !== 8'd1) $display("[TB] FAIL b2b_req1_rsp: got lat %0d data %0d expected lat 2 data 1", cyc, rsp1_data); else passes++;
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_steps = '0;   req1_steps = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      @(negedge clock);
      test_reset();
      test_basic();
      test_wrap();
      test_alternate();
      test_stall();
      test_reset_mid_run();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fib_arbiter.md
Name: fib_arbiter

Overview:
Shares one Fibonacci stepping datapath (a/b register pair, a <= a+b, b <= a, seeded a=b=1) between two requesters. Each requester submits a step count k. The block grants requesters round-robin, seeds and steps the datapath k times, and returns the term to the granted requester over a valid/ready response channel. It sits between client logic and the sequence generator and owns the generator's seeding and enable timing.

Parameters:
WIDTH, 8, datapath and result width; arithmetic wraps modulo 2^WIDTH
CNT_W, 8, width of step-count field and internal down-counter

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clock clock
req0_valid  input  1  requester 0 has a command
req0_steps  input  CNT_W  requester 0 step count k
req0_ready  output  1  command 0 accepted this cycle when high with req0_valid
req1_valid  input  1  requester 1 has a command
req1_steps  input  CNT_W  requester 1 step count k
req1_ready  output  1  command 1 accepted this cycle when high with req1_valid
rsp0_valid  output  1  result for requester 0 available
rsp0_data  output  WIDTH  result for requester 0
rsp0_ready  input  1  requester 0 takes result
rsp1_valid  output  1  result for requester 1 available
rsp1_data  output  WIDTH  result for requester 1
rsp1_ready  input  1  requester 1 takes result
busy  output  1  high in any state other than IDLE

Behaviour:
- States: IDLE, LOAD, RUN, RESP. Reset forces IDLE, a=1, b=1, cnt=0, owner=0, last_grant=1 (req0 wins first tie), all valid/ready outputs 0, rsp data 0, busy 0.
- IDLE: reqN_ready is combinational and high only for the granted requester. The grant is computed as follows.
  - Only one requester valid: that one is granted.
  - Both valid: the requester other than last_grant is granted.
  - Neither valid: no ready.
  - On handshake: latch owner and steps into cnt, update last_grant, go to LOAD.
- LOAD: a<=1, b<=1. If cnt==0 go to RESP, else go to RUN.
- RUN: each cycle a<=a+b (truncated to WIDTH), b<=a, cnt<=cnt-1. Leave to RESP on the cycle cnt goes 1->0.
- RESP: rsp<owner>_valid=1 and rsp<owner>_data=a, registered. The other rsp_valid stays 0. Hold valid and data stable while ready is low. On valid&ready, drop valid next cycle and return to IDLE.
- The ready input of the non-owner is ignored.
- Term mapping: k=0->1, 1->2, 2->3, 3->5, 4->8, so result = F(k+2) mod 2^WIDTH.
- Latency:
  - Command accepted at edge T.
  - rsp_valid rises at edge T+2+k if k>0.
  - rsp_valid rises at edge T+2 if k=0.
  - Back-to-back: the next accept can occur in the IDLE cycle immediately after the response handshake.
- Requests arriving while busy are not acknowledged; they must hold valid (standard valid/ready). reqN_ready is never high outside IDLE.
- Max k = 2^CNT_W-1; no overflow of cnt.
- Reset mid-operation (any state) aborts the command. No response is issued; next cycle is IDLE with reset values.

Test Plan:
- Reset, then req0 k=4 with rsp0_ready=1 -> req0_ready same cycle; rsp0_valid 6 cycles after accept with data 8; busy high throughout; rsp1_valid stays 0.
- req1 k=10 then k=12 -> data 144, then 121 (wrap of 377 mod 256); k=11 -> 233.
- req0 and req1 both valid continuously, k=0 each -> grants alternate 0,1,0,1 starting with 0; each response is data 1 at accept+2.
- rsp0_ready held low 5 cycles in RESP -> rsp0_valid and rsp0_data=5 (k=3) stay stable; req1_valid high meanwhile gets no ready until after the handshake.
- Assert reset during RUN of a k=20 command -> no rsp_valid; outputs return to reset values; a new req0 k=1 returns 2.
- req1 alone after reset, then both valid -> req1 served first, then req0 wins the tie (last_grant=1).
